// File: rtl/ramp_chk_pkg.sv
// Shared types and ramp predictor arithmetic for the ramp checker.
// Ramp math is done at 64 bits and truncated by the caller, so it wraps mod 2**WIDTH.
package ramp_chk_pkg;

  typedef enum logic {
    ORD_PROCESSING = 1'b0,
    ORD_NATURAL    = 1'b1
  } ramp_order_e;

  typedef struct packed {
    logic [63:0] exp_n;
    logic [63:0] hi_n;
  } ramp_state_t;

  function automatic int ramp_log2(input int m);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < m) r = i + 1;
    end
    return r;
  endfunction

  function automatic ramp_state_t ramp_next(input ramp_order_e order, input logic [63:0] exp_v,
                                            input logic [63:0] hi_v, input logic [63:0] m);
    logic [63:0] low;
    ramp_state_t s;
    low     = exp_v & (m - 64'd1);
    s.exp_n = exp_v;
    s.hi_n  = hi_v;
    case (order)
      ORD_NATURAL: s.exp_n = exp_v + 64'd1;
      ORD_PROCESSING: begin
        // Count down inside a block; at the block base jump to the top of the next block.
        s.exp_n = (low == 64'd0) ? hi_v - 64'd1 : exp_v - 64'd1;
        s.hi_n  = (low == 64'd1) ? hi_v + m : hi_v;
      end
      default: s.exp_n = exp_v;
    endcase
    return s;
  endfunction

  function automatic ramp_state_t ramp_resync(input ramp_order_e order, input logic [63:0] d,
                                              input logic [63:0] hi_v, input logic [63:0] m);
    logic [63:0] low;
    logic [63:0] b;
    ramp_state_t s;
    low     = d & (m - 64'd1);
    b       = (d & ~(m - 64'd1)) + m;
    s.exp_n = d + 64'd1;
    s.hi_n  = hi_v;
    case (order)
      ORD_NATURAL: s.exp_n = d + 64'd1;
      ORD_PROCESSING: begin
        s.exp_n = (low == 64'd0) ? b + m - 64'd1 : d - 64'd1;
        s.hi_n  = (low <= 64'd1) ? b + m : b;
      end
      default: s.exp_n = d + 64'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ramp_chk_if.sv
// AXI-stream style handshake bundle between the ramp source and the checker.
interface ramp_chk_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ramp_chk_exp_gen.sv
// Expected-value predictor: holds exp/hi and steps them on each accepted beat,
// or reloads them from the received data when resync is asserted.
module ramp_exp_gen
  import ramp_chk_pkg::*;
#(
  parameter int    WIDTH   = 16,
  parameter int    MAX_CNT = 64,
  parameter string ORDER   = "processing"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             resync,
  input  logic [WIDTH-1:0] resync_data,
  output logic [WIDTH-1:0] exp_o
);

  localparam ramp_order_e      ORD     = (ORDER == "natural") ? ORD_NATURAL : ORD_PROCESSING;
  localparam int               LOG2M   = ramp_log2(MAX_CNT);
  localparam logic [63:0]      M64     = 64'd1 << LOG2M;
  localparam logic [WIDTH-1:0] EXP_RST = (ORD == ORD_NATURAL) ? '0 : WIDTH'(MAX_CNT - 1);
  localparam logic [WIDTH-1:0] HI_RST  = WIDTH'(MAX_CNT);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  ramp_state_t      nxt_s;
  logic             unused_nxt_s;

  // Next-state selection: resync wins over a normal advance.
  always_comb begin
    nxt_s = '0;
    exp_d = exp_q;
    hi_d  = hi_q;
    if (resync) begin
      nxt_s = ramp_resync(ORD, 64'(resync_data), 64'(hi_q), M64);
      exp_d = nxt_s.exp_n[WIDTH-1:0];
      hi_d  = nxt_s.hi_n[WIDTH-1:0];
    end else if (advance) begin
      nxt_s = ramp_next(ORD, 64'(exp_q), 64'(hi_q), M64);
      exp_d = nxt_s.exp_n[WIDTH-1:0];
      hi_d  = nxt_s.hi_n[WIDTH-1:0];
    end else begin
      nxt_s = '0;
    end
  end

  assign unused_nxt_s = ^nxt_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= EXP_RST;
      hi_q  <= HI_RST;
    end else begin
      exp_q <= exp_d;
      hi_q  <= hi_d;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/ramp_chk.sv
// AXIS ramp sink/checker: paced tready, per-beat compare, counters, first-error capture.
// Optional RAMP_CHK_RESYNC_EN: reload the predictor from a mismatching beat.
module ramp_chk
  import ramp_chk_pkg::*;
#(
  parameter int    WIDTH       = 16,
  parameter int    MAX_CNT     = 64,
  parameter string ORDER       = "processing",
  parameter int    READY_PER   = 64,
  parameter int    READY_ON    = 48,
  parameter int    READY_START = 47,
  parameter int    CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  ramp_chk_if.slave        s_axis,
  input  logic             en,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic             first_err_vld,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] first_err_exp
);

  localparam int            PW       = $clog2(READY_PER + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(READY_PER - 1);
  localparam logic [PW-1:0] PH_ON    = PW'(READY_ON);
  localparam logic [PW-1:0] PH_START = PW'(READY_START);

  logic [PW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0] fe_got_q, fe_got_d;
  logic [WIDTH-1:0] fe_exp_q, fe_exp_d;
  logic             tready_s, accept_s, mismatch_s, resync_s;
  logic [WIDTH-1:0] exp_s;

  ramp_exp_gen #(
    .WIDTH   (WIDTH),
    .MAX_CNT (MAX_CNT),
    .ORDER   (ORDER)
  ) u_exp_gen (
    .clk         (clk),
    .rst         (rst),
    .advance     (accept_s),
    .resync      (resync_s),
    .resync_data (s_axis.tdata),
    .exp_o       (exp_s)
  );

  // Handshake, compare and next-state for the counters and first-error capture.
  always_comb begin
    phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    tready_s   = en && (phase_q < PH_ON);
    accept_s   = s_axis.tvalid && tready_s;
    mismatch_s = accept_s && (s_axis.tdata != exp_s);
`ifdef RAMP_CHK_RESYNC_EN
    resync_s   = mismatch_s;
`else
    resync_s   = 1'b0;
`endif
    beat_cnt_d = accept_s ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
    err_cnt_d  = (mismatch_s && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    err_d      = mismatch_s;
    fe_vld_d   = fe_vld_q;
    fe_got_d   = fe_got_q;
    fe_exp_d   = fe_exp_q;
    if (mismatch_s && !fe_vld_q) begin
      fe_vld_d = 1'b1;
      fe_got_d = s_axis.tdata;
      fe_exp_d = exp_s;
    end else begin
      fe_vld_d = fe_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_START;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
      fe_vld_q   <= 1'b0;
      fe_got_q   <= '0;
      fe_exp_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
      fe_vld_q   <= fe_vld_d;
      fe_got_q   <= fe_got_d;
      fe_exp_q   <= fe_exp_d;
    end
  end

  assign s_axis.tready  = tready_s;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err            = err_q;
  assign first_err_vld  = fe_vld_q;
  assign first_err_got  = fe_got_q;
  assign first_err_exp  = fe_exp_q;

endmodule
